// File: rtl/icache_direct_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Holds the default geometry, the two-state refill FSM encoding and a
// saturating increment used by the optional ICACHE_PERF_CNT_EN counters.
package icache_direct_pkg;

  localparam int unsigned ICACHE_ADDR_W   = 32;
  localparam int unsigned ICACHE_DATA_W   = 32;
  localparam int unsigned ICACHE_INDEX_W  = 4;
  localparam int unsigned ICACHE_OFFSET_W = 2;
  localparam int unsigned ICACHE_WORDS    = 4;
  localparam int unsigned ICACHE_CNT_W    = 32;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ICACHE_CNT_W-1:0] sat_inc(input logic [ICACHE_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache_direct_tag_array.sv
// Valid/tag storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst                   clock, async active-high reset (clears valid only)
//   lookup_index, lookup_tag   lookup address fields
//   hit_c                      combinational hit for the lookup fields
//   flush                      clears every valid bit at the edge
//   wr_en, wr_index, wr_tag    line write at end of a refill
//   wr_valid                   valid value stored with the written line
module icache_tag_array
  import icache_direct_pkg::*;
#(
  parameter int unsigned INDEX_W = ICACHE_INDEX_W,
  parameter int unsigned TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit_c,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  // Lookup always sees the pre-edge valid bits, so a same-cycle flush does not hide a hit.
  assign hit_c = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

  // Flush clears first; a completing line write then sets its own entry.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end
    if (wr_en) begin
      valid_d[wr_index] = wr_valid;
    end
  end

  always_comb begin
    tag_d = tag_q;
    if (wr_en) begin
      tag_d[wr_index] = wr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache between the core fetch port and a
// req/ack backing memory. Hits return data combinationally; misses stall
// and refill a 4-word line one word per ack.
// Ports:
//   clk, rst            clock, async active-high reset
//   rom_en, rom_addr    fetch request and byte address (bits [1:0] ignored)
//   rom_inst            fetched instruction (combinational)
//   inst_stall          fetch cannot be served this cycle (combinational)
//   inst_flush          one-cycle pulse invalidating all lines
//   mem_req, mem_addr   registered backing read request / word address
//   mem_ack, mem_rdata  backing read data valid / data
//   hit_cnt, miss_cnt   saturating perf counters, only with ICACHE_PERF_CNT_EN
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int unsigned ADDR_W         = ICACHE_ADDR_W,
  parameter int unsigned DATA_W         = ICACHE_DATA_W,
  parameter int unsigned INDEX_W        = ICACHE_INDEX_W,
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_inst,
  output logic              inst_stall,
  input  logic              inst_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [ICACHE_CNT_W-1:0] hit_cnt,
  output logic [ICACHE_CNT_W-1:0] miss_cnt
`endif
);

  localparam int unsigned LINE_W = ADDR_W - ICACHE_OFFSET_W - 2;
  localparam int unsigned TAG_W  = LINE_W - INDEX_W;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam logic [ICACHE_OFFSET_W-1:0] LAST_WORD = ICACHE_OFFSET_W'(WORDS_PER_LINE - 1);

  // Fetch address split.
  logic [ICACHE_OFFSET_W-1:0] rd_off;
  logic [INDEX_W-1:0]         rd_index;
  logic [TAG_W-1:0]           rd_tag;
  logic                       unused_addr_bits;

  assign rd_off           = rom_addr[3:2];
  assign rd_index         = rom_addr[INDEX_W+3:4];
  assign rd_tag           = rom_addr[ADDR_W-1:INDEX_W+4];
  assign unused_addr_bits = ^rom_addr[1:0];

  icache_state_e              state_q, state_d;
  logic [ICACHE_OFFSET_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LINE_W-1:0]          line_q, line_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic                       discard_q, discard_d;
  logic [DATA_W-1:0]          data_q [LINES][WORDS_PER_LINE];
  logic [DATA_W-1:0]          data_d [LINES][WORDS_PER_LINE];

  logic               hit_c;
  logic               miss_start;
  logic               last_ack;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;

  assign wr_index   = line_q[INDEX_W-1:0];
  assign wr_tag     = line_q[LINE_W-1:INDEX_W];
  assign cnt_inc    = cnt_q + 1'b1;
  assign miss_start = (state_q == ICACHE_IDLE) && rom_en && !hit_c;
  assign last_ack   = (state_q == ICACHE_REFILL) && mem_ack && (cnt_q == LAST_WORD);

  // A flush landing in the final ack cycle must also leave the line invalid.
  icache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_array (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (rd_index),
    .lookup_tag   (rd_tag),
    .hit_c        (hit_c),
    .flush        (inst_flush),
    .wr_en        (last_ack),
    .wr_index     (wr_index),
    .wr_tag       (wr_tag),
    .wr_valid     (!(discard_q || inst_flush))
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ICACHE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ICACHE_IDLE:   if (miss_start) state_d = ICACHE_REFILL;
      ICACHE_REFILL: if (last_ack)   state_d = ICACHE_IDLE;
      default:       state_d = ICACHE_IDLE;
    endcase
  end

  // FSM outputs toward the core; forced to reset values while rst is high.
  always_comb begin
    rom_inst   = '0;
    inst_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ICACHE_IDLE: begin
          if (rom_en) begin
            if (hit_c) begin
              rom_inst = data_q[rd_index][rd_off];
            end else begin
              inst_stall = 1'b1;
            end
          end
        end
        ICACHE_REFILL: inst_stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Refill datapath: line latch, word counter, memory request and data writes.
  always_comb begin
    cnt_d      = cnt_q;
    line_d     = line_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    data_d     = data_q;
    if (miss_start) begin
      line_d     = {rd_tag, rd_index};
      cnt_d      = '0;
      mem_req_d  = 1'b1;
      mem_addr_d = {rd_tag, rd_index, 4'b0000};
    end
    if (state_q == ICACHE_REFILL) begin
      if (inst_flush) begin
        discard_d = 1'b1;
      end
      if (mem_ack) begin
        data_d[wr_index][cnt_q] = mem_rdata;
        cnt_d = cnt_inc;
        if (cnt_q == LAST_WORD) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
        end else begin
          mem_addr_d = {line_q, cnt_inc, 2'b00};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      line_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
    end
  end

  // Instruction words are qualified by the tag array, so no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [ICACHE_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [ICACHE_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Flush wins over a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (inst_flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if ((state_q == ICACHE_IDLE) && rom_en && hit_c) begin
        hit_cnt_d = sat_inc(hit_cnt_q);
      end
      if (miss_start) begin
        miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed miss/refill sequences,
// a table of hit vectors, flush and reset corner cases.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        inst_stall;
  logic        inst_flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Backing memory contents: word k of line L is {L,4'h0} ^ 0x11*(k+1).
  function automatic logic [31:0] data_of(input logic [31:0] a);
    logic [31:0] k;
    k = {30'd0, a[3:2]} + 32'd1;
    return {a[31:4], 4'h0} ^ (32'h11 * k);
  endfunction

  assign mem_rdata = data_of(mem_addr);

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_inst   (rom_inst),
    .inst_stall (inst_stall),
    .inst_flush (inst_flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Memory model: first word after first_lat wait cycles, later words after gap wait cycles.
  int first_lat_cfg = 1;
  int gap_cfg       = 0;
  int ack_wait      = 0;
  bit ack_first     = 1'b1;

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mem_req) begin
        mem_ack   = 1'b0;
        ack_wait  = 0;
        ack_first = 1'b1;
      end else begin
        if (mem_ack) begin
          ack_first = 1'b0;
          ack_wait  = 0;
        end
        if (ack_wait >= (ack_first ? first_lat_cfg : gap_cfg)) begin
          mem_ack = 1'b1;
        end else begin
          mem_ack = 1'b0;
          ack_wait++;
        end
      end
    end
  end

  // Fetch addr from IDLE through a complete refill; checks addresses, stall length, result.
  task automatic run_miss(input logic [31:0] addr, input int flat, input int gap,
                          input int exp_stalls);
    logic [31:0] base;
    int k, stalls, cyc;
    base          = addr & 32'hFFFF_FFF0;
    first_lat_cfg = flat;
    gap_cfg       = gap;
    rom_en        = 1'b1;
    rom_addr      = addr;
    #1;
    k = 0; stalls = 0; cyc = 0;
    while (inst_stall && cyc < 200) begin
      if (mem_req) check("refill_addr", mem_addr, base + 32'(4 * k));
      if (mem_req && mem_ack) k++;
      stalls++;
      cyc++;
      @(posedge clk);
      #2;
    end
    if (cyc >= 200) timeout("refill");
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("refill_words", 32'(k), 32'd4);
    check("refill_inst", rom_inst, data_of(addr));
    check("req_dropped", {31'd0, mem_req}, 32'd0);
  endtask

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        stall;
    logic        req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc, k;

    // Line 0 holds 0x0..0xC, line 2 holds 0x20..0x2C when the table runs.
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h0000_0033, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0011, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'h0000_0022, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_000C, 32'h0000_0044, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_000B, 32'h0000_0033, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0020, 32'h0000_0031, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0024, 32'h0000_0002, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0028, 32'h0000_0013, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_002C, 32'h0000_0064, 1'b0, 1'b0};

    rst        = 1'b1;
    rom_en     = 1'b0;
    rom_addr   = '0;
    inst_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_rom_inst", rom_inst, 32'd0);
    check("rst_stall", {31'd0, inst_stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // Cold miss, then conflicting tag at index 0, then the original line again.
    run_miss(32'h0000_0000, 1, 0, 6);
    run_miss(32'h0000_0100, 1, 0, 6);
    run_miss(32'h0000_0000, 1, 0, 6);
    // Three idle cycles between acks: 1 + 1 + 4 + 3*3 stall cycles.
    run_miss(32'h0000_0020, 1, 3, 15);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 rom_en = vecs[i].en; rom_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_inst", i), rom_inst, vecs[i].inst);
      check($sformatf("vec%0d_stall", i), {31'd0, inst_stall}, {31'd0, vecs[i].stall});
      check($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].req});
    end

    // Flush in IDLE: same-cycle lookup still hits, next cycle misses.
    @(posedge clk);
    #1 rom_en = 1'b1; rom_addr = 32'h0000_0008; inst_flush = 1'b1;
    #1;
    check("flush_same_cycle_inst", rom_inst, 32'h0000_0033);
    check("flush_same_cycle_stall", {31'd0, inst_stall}, 32'd0);
    @(posedge clk);
    #1 inst_flush = 1'b0;
    #1;
    check("flush_after_stall", {31'd0, inst_stall}, 32'd1);
    check("flush_after_inst", rom_inst, 32'd0);
    run_miss(32'h0000_0008, 1, 0, 6);

    // Flush at the 2nd ack: refill finishes but the line stays invalid.
    first_lat_cfg = 1;
    gap_cfg       = 0;
    @(posedge clk);
    #1 rom_en = 1'b1; rom_addr = 32'h0000_0040;
    #1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      if (mem_req && mem_ack) begin
        if (k == 1) inst_flush = 1'b1;
        k++;
      end
      @(posedge clk);
      #1 inst_flush = 1'b0;
      #1;
      cyc++;
    end
    if (cyc >= 100) timeout("discard_refill");
    check("discard_remiss_stall", {31'd0, inst_stall}, 32'd1);
    check("discard_remiss_inst", rom_inst, 32'd0);
    @(posedge clk);
    #2;
    check("discard_rerefill_req", {31'd0, mem_req}, 32'd1);
    check("discard_rerefill_addr", mem_addr, 32'h0000_0040);
    cyc = 0;
    while (inst_stall && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (cyc >= 100) timeout("rerefill");
    check("discard_final_inst", rom_inst, 32'h0000_0051);

    // Reset in the middle of a refill.
    @(posedge clk);
    #1 rom_addr = 32'h0000_0060; rom_en = 1'b1; first_lat_cfg = 1; gap_cfg = 3;
    #1;
    cyc = 0;
    while (!(mem_req && mem_ack) && cyc < 50) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (cyc >= 50) timeout("midrefill_ack");
    rst    = 1'b1;
    rom_en = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_stall", {31'd0, inst_stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rom_addr = 32'h0000_0040; rom_en = 1'b1;
    #1;
    check("post_reset_miss", {31'd0, inst_stall}, 32'd1);
    run_miss(32'h0000_0040, 1, 0, 6);

`ifdef ICACHE_PERF_CNT_EN
    @(posedge clk);
    #1 rom_en = 1'b0; inst_flush = 1'b1;
    @(posedge clk);
    #1 inst_flush = 1'b0;
    #1;
    check("perf_clear_hit", hit_cnt, 32'd0);
    check("perf_clear_miss", miss_cnt, 32'd0);
    run_miss(32'h0000_0080, 1, 0, 6);
    @(posedge clk);
    #1 rom_addr = 32'h0000_0088;
    repeat (3) @(posedge clk);
    #1 rom_en = 1'b0;
    #1;
    check("perf_hit_cnt", hit_cnt, 32'd4);
    check("perf_miss_cnt", miss_cnt, 32'd1);
    @(posedge clk);
    #1 inst_flush = 1'b1;
    @(posedge clk);
    #1 inst_flush = 1'b0;
    #1;
    check("perf_flush_hit", hit_cnt, 32'd0);
    check("perf_flush_miss", miss_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the CPU core's fetch port (rom_en/rom_addr/rom_inst) and a slower backing instruction memory that uses a req/ack handshake.
- Hits return the instruction combinationally in the same cycle, so it is a drop-in replacement for a combinational ROM.
- Misses raise inst_stall and refill a 4-word line in a burst.
- The core holds PC and IF_ID while inst_stall is high.

Parameters:
- ADDR_W, 32, address width (matches ADDR_BUS).
- DATA_W, 32, instruction width (matches INST_BUS).
- INDEX_W, 4, index bits; 2^INDEX_W lines.
- WORDS_PER_LINE, 4, words per line; fixed at 4 (offset field is 2 bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rom_en  in  1  fetch request from core PC.
- rom_addr  in  ADDR_W  byte address of fetch; bits [1:0] ignored.
- rom_inst  out  DATA_W  fetched instruction.
- inst_stall  out  1  high while the fetch cannot be served.
- inst_flush  in  1  one-cycle pulse; invalidates all lines.
- mem_req  out  1  backing memory read request.
- mem_addr  out  ADDR_W  word-aligned backing read address.
- mem_ack  in  1  backing memory data valid for the current mem_addr.
- mem_rdata  in  DATA_W  backing read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Address split: offset = rom_addr[3:2], index = rom_addr[3+INDEX_W:4], tag = rom_addr[ADDR_W-1:4+INDEX_W].
- Storage:
  - valid[] is reset to 0.
  - tag[] and data[] are not reset.
- Reset values: rom_inst=0, inst_stall=0, mem_req=0, mem_addr=0, state=IDLE, refill counter=0, discard flag=0.
- FSM has two states, IDLE and REFILL.
- IDLE:
  - rom_en=0: rom_inst=0, inst_stall=0.
  - rom_en=1 and hit (valid[index] and tag match): rom_inst=data[index][offset] combinationally, inst_stall=0.
  - rom_en=1 and miss: inst_stall=1 combinationally, rom_inst=0. Next edge: latch line base {tag,index,4'b0}, go REFILL, cnt=0.
- REFILL:
  - mem_req=1 and mem_addr=base+cnt*4, registered; both are stable until mem_ack.
  - On each cycle with mem_ack=1: data[index][cnt]<=mem_rdata, cnt++.
  - On the 4th ack: tag[index]<=tag, valid[index]<=!discard; mem_req deasserts the next cycle; return to IDLE.
  - The retried access hits one cycle after refill completes, so the minimum miss penalty is 4 ack cycles + 2.
  - inst_stall=1 throughout REFILL regardless of rom_en.
- Boundary conditions:
  - Back-to-back acks are legal (1 word/cycle). Arbitrary ack gaps are legal.
  - rom_en dropping mid-refill: the refill still completes.
  - rom_addr is required stable while inst_stall=1; a change during REFILL is not tracked, and the new address is looked up after return to IDLE.
  - inst_flush in IDLE: all valid cleared at the edge. A lookup in the same cycle uses the pre-flush valid bits.
  - inst_flush in REFILL: all valid cleared and discard=1. The in-flight line completes but is left invalid, so the core re-misses. discard is cleared on entry to IDLE.
  - Reset mid-refill: immediate return to reset values. Any outstanding mem_ack after reset is ignored.
  - Index aliasing: a refill overwrites the previous line at that index.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds output ports hit_cnt and miss_cnt, each 32-bit, both reset to 0.
  - hit_cnt increments on each IDLE cycle with rom_en=1 and a hit.
  - miss_cnt increments once per IDLE->REFILL transition.
  - Both saturate at 32'hFFFF_FFFF and are cleared by inst_flush.
- Not defined: the ports and counters are absent, and core behaviour is identical.

Decomposition:
- Shared define file gains:
  - state encodings ICACHE_IDLE and ICACHE_REFILL.
  - ICACHE_INDEX_W default.
  - ICACHE_OFFSET_W=2.
- One natural sub-module: icache_tag_array, holding the valid/tag storage with lookup compare, flush clear and line write.
- The data array and FSM stay in icache_direct.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, rom_en=1, rom_addr=0x00000000; memory acks every cycle with data 0x11,0x22,0x33,0x44.
   - Response: mem_addr sequences 0x0,0x4,0x8,0xC; inst_stall high 6 cycles; then rom_inst=0x11 with stall=0.
2. Line hit:
   - Stimulus: after scenario 1, rom_addr=0x8.
   - Response: same-cycle rom_inst=0x33, mem_req stays 0.
3. Conflict:
   - Stimulus: fetch 0x00000100 (same index 0, different tag), then 0x0.
   - Response: both miss and refill; the second refill re-reads 0x0-0xC.
4. Ack gaps:
   - Stimulus: mem_ack with 3 idle cycles between words.
   - Response: mem_addr holds each value until its ack; refilled data is correct.
5. Flush during refill:
   - Stimulus: inst_flush pulsed at 2nd ack.
   - Response: refill completes; the next fetch of the same address misses again.
   - Also: reset asserted mid-refill gives mem_req=0 immediately and all lines miss afterwards.
6. Perf counters (macro defined):
   - Stimulus: scenarios 1 then 2.
   - Response: miss_cnt=1; hit_cnt counts hit cycles exactly; inst_flush zeroes both.
